mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter AW, default 3, the RAM word-address width (8 words of 16 bits); the byte address is AW+1 bits.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, controller can accept.
REQ-006 SHALL have port req_wr, input, 1, 1=write, 0=read.
REQ-007 SHALL have port req_size, input, 1, 0=byte, 1=halfword.
REQ-008 SHALL have port req_baddr, input, AW+1, little-endian byte address.
REQ-009 SHALL have port req_wdata, input, 16; a byte write uses bits [7:0].
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 16, read result (0 for writes).
REQ-012 SHALL have ports ram_we (output, 1), ram_byte_en (output, 2), ram_addr (output, AW) and ram_data_in (output, 16) to drive the RAM, plus ram_data_out (input, 16) from it; the RAM writes enabled lanes on the clock edge and registers the read word, so the word is valid one cycle after the address.

Function
REQ-013 SHALL accept a request only on a clock edge with req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE, and the request fields SHALL be registered at acceptance and ignored otherwise.
REQ-014 SHALL use FSM IDLE->ACC1->(ACC2 if split)->DONE->IDLE; each state SHALL last exactly one cycle.
REQ-015 SHALL derive word = baddr[AW:1] and lane = baddr[0]; split = (size=1 and lane=1).
REQ-016 SHALL, in ACC1, drive ram_addr=word and ram_we=req_wr; in ACC2, drive ram_addr=(word+1) mod 2^AW (word 7 wraps to word 0).
REQ-017 Byte write SHALL drive ram_byte_en=01 (lane 0) or 10 (lane 1), with ram_data_in={wdata[7:0],wdata[7:0]}.
REQ-018 Aligned halfword write SHALL drive ram_byte_en=11 and ram_data_in=wdata in ACC1 only.
REQ-019 Split write SHALL drive byte_en=10 with {wdata[7:0],8'h00} in ACC1, then byte_en=01 with {8'h00,wdata[15:8]} in ACC2.
REQ-020 Reads SHALL drive ram_we=0; outside ACC1/ACC2, ram_we=0, ram_byte_en=00, ram_addr=0 and ram_data_in=0.
REQ-021 In ACC2, SHALL capture ram_data_out[15:8] (first word's upper byte) into a hold register.
REQ-022 In DONE, rsp_valid=1 and rsp_rdata SHALL be formed combinationally from ram_data_out:
- byte read: {8'h00, selected lane}
- aligned halfword read: ram_data_out
- split read: {ram_data_out[7:0], hold}
- write: 16'h0000
REQ-023 Latency from the acceptance edge to rsp_valid SHALL be 2 cycles unsplit and 3 cycles split; the next acceptance SHALL occur no earlier than the edge ending DONE+1 (IDLE).
REQ-024 rsp_valid SHALL be 0 and rsp_rdata SHALL be 0 in all states other than DONE.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, req_ready=1 after release, and all RAM-side outputs, rsp_valid, rsp_rdata and hold to 0.
REQ-026 Reset during ACC2 of a split write SHALL abandon the access; the byte already written in ACC1 SHALL remain, with no rollback and no response.

Structure
REQ-027 A shared package mem_pkg SHALL hold the FSM state encoding (IDLE, ACC1, ACC2, DONE) and the constants SIZE_BYTE=0 and SIZE_HALF=1.
REQ-028 SHALL be a single module with no sub-modules; lane steering stays inline.

Verification
REQ-029 Bench SHALL pair the DUT with an 8x16 byte-enable RAM model that has registered read and is zero-initialised.
REQ-030 Byte write baddr=5, wdata=0x00AB; then halfword read baddr=4 -> rsp_rdata=0xAB00, rsp_valid 2 cycles after acceptance.
REQ-031 Aligned halfword write baddr=6, 0x1234; then byte reads baddr 6 and 7 -> 0x0034 and 0x0012.
REQ-032 Split write baddr=15, 0xBEEF -> word7[15:8]=0xEF and word0[7:0]=0xBE; split read baddr=15 -> 0xBEEF with 3-cycle latency.
REQ-033 req_valid held high back-to-back -> each acceptance only in IDLE; no overlapping RAM cycles; one rsp_valid pulse per request.
REQ-034 rst asserted in ACC2 of split write baddr=3, 0xCAFE -> outputs 0 immediately; word1[15:8]=0xFE, word2[7:0] unchanged; no rsp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller.
// Holds the FSM state encoding and the access-size codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

endpackage

// File: rtl/mem_req_ctrl.sv
// Byte/halfword request controller in front of a 16-bit byte-enable RAM with a registered read.
// A halfword at an odd byte address is split across two consecutive words, wrapping at the top.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic          req_size,
    input  logic [AW:0]   req_baddr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    output logic [15:0]   rsp_rdata,
    output logic          ram_we,
    output logic [1:0]    ram_byte_en,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_data_in,
    input  logic [15:0]   ram_data_out
);

    state_t        state;
    state_t        state_next;
    logic          wr_q;
    logic          size_q;
    logic          lane_q;
    logic [AW-1:0] word_q;
    logic [15:0]   wdata_q;
    logic [7:0]    hold_q;
    logic          accept;
    logic          split;

    assign accept = req_valid && (state == IDLE);
    assign split  = (size_q == SIZE_HALF) && lane_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path leaves the signal unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACC1;
            ACC1:    state_next = split ? ACC2 : DONE;
            ACC2:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; hold keeps the first word's upper byte of a split read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            lane_q  <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr;
                size_q  <= req_size;
                lane_q  <= req_baddr[0];
                word_q  <= req_baddr[AW:1];
                wdata_q <= req_wdata;
            end
            if (state == ACC2) begin
                hold_q <= ram_data_out[15:8];
            end
        end
    end

    always_comb begin
        req_ready   = (state == IDLE);
        ram_we      = 1'b0;
        ram_byte_en = 2'b00;
        ram_addr    = '0;
        ram_data_in = '0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        case (state)
            ACC1: begin
                ram_addr = word_q;
                ram_we   = wr_q;
                if (wr_q) begin
                    if (size_q == SIZE_BYTE) begin
                        ram_byte_en = lane_q ? 2'b10 : 2'b01;
                        ram_data_in = {2{wdata_q[7:0]}};
                    end else if (lane_q) begin
                        ram_byte_en = 2'b10;
                        ram_data_in = {wdata_q[7:0], 8'h00};
                    end else begin
                        ram_byte_en = 2'b11;
                        ram_data_in = wdata_q;
                    end
                end
            end
            ACC2: begin
                ram_addr = word_q + AW'(1);
                ram_we   = wr_q;
                if (wr_q) begin
                    ram_byte_en = 2'b01;
                    ram_data_in = {8'h00, wdata_q[15:8]};
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (!wr_q) begin
                    if (size_q == SIZE_BYTE) begin
                        rsp_rdata = {8'h00, (lane_q ? ram_data_out[15:8] : ram_data_out[7:0])};
                    end else if (lane_q) begin
                        rsp_rdata = {ram_data_out[7:0], hold_q};
                    end else begin
                        rsp_rdata = ram_data_out;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: a zero-initialised 8x16 byte-enable RAM model with registered read,
// directed requests, and a scoreboard of expected responses popped when rsp_valid pulses.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic          req_size;
    logic [AW:0]   req_baddr;
    logic [15:0]   req_wdata;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          ram_we;
    logic [1:0]    ram_byte_en;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_data_in;
    logic [15:0]   ram_data_out = 16'h0000;

    logic [15:0] mem [8] = '{default: 16'h0000};

    typedef struct {
        logic [15:0] rdata;
        int          acc_cyc;
        bit          split;
        int          id;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic        size;
        logic [3:0]  baddr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } step_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_issued = 0;
    int   n_rsp = 0;
    logic rsp_prev = 1'b0;

    // Expected read data follows from the RAM contents built up by the earlier steps in this list.
    step_t b2b [5] = '{
        '{1'b1, SIZE_HALF, 4'd8, 16'hA1B2, 16'h0000},
        '{1'b0, SIZE_HALF, 4'd8, 16'h0000, 16'hA1B2},
        '{1'b1, SIZE_BYTE, 4'd9, 16'h00C3, 16'h0000},
        '{1'b0, SIZE_HALF, 4'd9, 16'h0000, 16'h00C3},
        '{1'b0, SIZE_HALF, 4'd8, 16'h0000, 16'hC3B2}
    };

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_req_ctrl #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_baddr    (req_baddr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_we       (ram_we),
        .ram_byte_en  (ram_byte_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_byte_en[0]) mem[ram_addr][7:0]  <= ram_data_in[7:0];
            if (ram_byte_en[1]) mem[ram_addr][15:8] <= ram_data_in[15:8];
        end
        ram_data_out <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_prev) check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
            if (rsp_valid) begin
                n_rsp++;
                check("rsp_expected", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check($sformatf("rsp%0d_rdata", e.id), {16'd0, rsp_rdata}, {16'd0, e.rdata});
                    check($sformatf("rsp%0d_latency", e.id), cyc - e.acc_cyc + 1, e.split ? 3 : 2);
                end
            end else begin
                check("rdata_zero_outside_done", {16'd0, rsp_rdata}, 32'd0);
            end
        end
        rsp_prev = rsp_valid;
    end

    // Drives a request and returns at the negedge after acceptance, i.e. during ACC1.
    task automatic issue(input logic wr, input logic size, input logic [3:0] baddr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata,
                         input bit expect_rsp, output int acc);
        int n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_baddr = baddr;
        req_wdata = wdata;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_within_bound", {31'd0, req_ready}, 32'd1);
        acc = cyc + 1;
        if (req_ready && expect_rsp) begin
            q.push_back('{rdata: exp_rdata, acc_cyc: acc, split: (size == SIZE_HALF) && baddr[0], id: n_issued});
            n_issued++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        req_valid = 1'b0;
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rsp_within_bound", q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int prev_acc;
        prev_acc  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_size  = SIZE_BYTE;
        req_baddr = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_be", {30'd0, ram_byte_en}, 32'd0);
        check("rst_addr", {29'd0, ram_addr}, 32'd0);
        check("rst_din", {16'd0, ram_data_in}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Byte write to lane 1 of word 2, then aligned halfword read of that word.
        issue(1'b1, SIZE_BYTE, 4'd5, 16'h00AB, 16'h0000, 1'b1, acc);
        check("bw5_we", {31'd0, ram_we}, 32'd1);
        check("bw5_be", {30'd0, ram_byte_en}, 32'd2);
        check("bw5_addr", {29'd0, ram_addr}, 32'd2);
        check("bw5_din", {16'd0, ram_data_in}, 32'h0000ABAB);
        check("bw5_busy", {31'd0, req_ready}, 32'd0);
        wait_idle();
        issue(1'b0, SIZE_HALF, 4'd4, 16'hFFFF, 16'hAB00, 1'b1, acc);
        check("hr4_we", {31'd0, ram_we}, 32'd0);
        check("hr4_addr", {29'd0, ram_addr}, 32'd2);
        wait_idle();

        // Aligned halfword write, then both byte lanes read back.
        issue(1'b1, SIZE_HALF, 4'd6, 16'h1234, 16'h0000, 1'b1, acc);
        check("hw6_be", {30'd0, ram_byte_en}, 32'd3);
        check("hw6_din", {16'd0, ram_data_in}, 32'h00001234);
        check("hw6_addr", {29'd0, ram_addr}, 32'd3);
        wait_idle();
        issue(1'b0, SIZE_BYTE, 4'd6, 16'hFFFF, 16'h0034, 1'b1, acc);
        wait_idle();
        issue(1'b0, SIZE_BYTE, 4'd7, 16'hFFFF, 16'h0012, 1'b1, acc);
        wait_idle();

        // Split write at the top byte wraps into word 0.
        issue(1'b1, SIZE_HALF, 4'd15, 16'hBEEF, 16'h0000, 1'b1, acc);
        check("sw15_acc1_addr", {29'd0, ram_addr}, 32'd7);
        check("sw15_acc1_be", {30'd0, ram_byte_en}, 32'd2);
        check("sw15_acc1_din", {16'd0, ram_data_in}, 32'h0000EF00);
        @(negedge clk);
        check("sw15_acc2_we", {31'd0, ram_we}, 32'd1);
        check("sw15_acc2_addr", {29'd0, ram_addr}, 32'd0);
        check("sw15_acc2_be", {30'd0, ram_byte_en}, 32'd1);
        check("sw15_acc2_din", {16'd0, ram_data_in}, 32'h000000BE);
        wait_idle();
        check("sw15_word7", {16'd0, mem[7]}, 32'h0000EF00);
        check("sw15_word0", {16'd0, mem[0]}, 32'h000000BE);
        issue(1'b0, SIZE_HALF, 4'd15, 16'h0000, 16'hBEEF, 1'b1, acc);
        wait_idle();

        // Reset in ACC2 of a split write: first byte stays, second never lands, no response.
        issue(1'b1, SIZE_BYTE, 4'd4, 16'h0055, 16'h0000, 1'b1, acc);
        wait_idle();
        issue(1'b1, SIZE_HALF, 4'd3, 16'hCAFE, 16'h0000, 1'b0, acc);
        check("abort_acc1_addr", {29'd0, ram_addr}, 32'd1);
        check("abort_acc1_din", {16'd0, ram_data_in}, 32'h0000FE00);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_acc2_addr", {29'd0, ram_addr}, 32'd2);
        check("abort_acc2_be", {30'd0, ram_byte_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we", {31'd0, ram_we}, 32'd0);
        check("abort_be", {30'd0, ram_byte_en}, 32'd0);
        check("abort_addr", {29'd0, ram_addr}, 32'd0);
        check("abort_din", {16'd0, ram_data_in}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_word1", {16'd0, mem[1]}, 32'h0000FE00);
        check("abort_word2", {16'd0, mem[2]}, 32'h0000AB55);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, SIZE_HALF, 4'd3, 16'h0000, 16'h55FE, 1'b1, acc);
        wait_idle();

        // Back-to-back with req_valid held high: acceptances spaced by the full FSM walk.
        for (int i = 0; i < 5; i++) begin
            issue(b2b[i].wr, b2b[i].size, b2b[i].baddr, b2b[i].wdata, b2b[i].rdata, 1'b1, acc);
            if (i > 0) begin
                check($sformatf("b2b%0d_gap", i), acc - prev_acc,
                      ((b2b[i-1].size == SIZE_HALF) && b2b[i-1].baddr[0]) ? 4 : 3);
            end
            prev_acc = acc;
        end
        wait_idle();

        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        check("rsp_count", n_rsp, n_issued);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
